// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: sequenced ALU control decoder. Decodes one ALU request per
// valid/ready handshake into ALU control codes. Multi-bit shifts issue as a
// burst of 1-bit shift commands.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready handshake with
// alu_op, funct, shamt; stall freezes the sequencer; outputs alu_ctrl,
// alu_b_zero, ctrl_valid, ctrl_last, step, busy.
// Option: define ALU_SEQ_FLUSH_EN to add the flush input (burst abort).
module alu_ctrl_seq #(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [2:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               stall,
`ifdef ALU_SEQ_FLUSH_EN
    input  logic               flush,
`endif
    output logic [2:0]         alu_ctrl,
    output logic               alu_b_zero,
    output logic               ctrl_valid,
    output logic               ctrl_last,
    output logic [SHAMT_W-1:0] step,
    output logic               busy
);

    localparam logic [2:0] C_ADD  = 3'd0;
    localparam logic [2:0] C_SUB  = 3'd1;
    localparam logic [2:0] C_AND  = 3'd2;
    localparam logic [2:0] C_OR   = 3'd3;
    localparam logic [2:0] C_XOR  = 3'd4;
    localparam logic [2:0] C_SHL1 = 3'd5;
    localparam logic [2:0] C_SHR1 = 3'd6;
    localparam logic [2:0] C_PASS = 3'd7;

    localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic               bz_q, bz_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic [SHAMT_W-1:0] step_q, step_d;
    // Captured shift amount; the burst length is fixed at accept.
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    logic       accept;
    logic [2:0] dec_code;
    logic       dec_shift;

    assign in_ready = !stall
                    && (state_q == IDLE || (valid_q && last_q));
    assign accept   = in_valid && in_ready;

    assign alu_ctrl   = ctrl_q;
    assign alu_b_zero = bz_q;
    assign ctrl_valid = valid_q;
    assign ctrl_last  = last_q;
    assign step       = step_q;
    assign busy       = busy_q;

    always_comb begin
        dec_code  = C_ADD;
        dec_shift = 1'b0;
        unique case (alu_op)
            2'b00: dec_code = C_ADD;
            2'b01: dec_code = C_SUB;
            2'b11: dec_code = C_PASS;
            2'b10: begin
                unique case (funct)
                    3'b000: dec_code = C_ADD;
                    3'b001: dec_code = C_SUB;
                    3'b010: dec_code = C_AND;
                    3'b011: dec_code = C_OR;
                    3'b100: dec_code = C_XOR;
                    3'b101: begin
                        dec_code  = C_SHL1;
                        dec_shift = 1'b1;
                    end
                    3'b110: begin
                        dec_code  = C_SHR1;
                        dec_shift = 1'b1;
                    end
                    3'b111: dec_code = C_PASS;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        bz_d    = bz_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            if (accept) begin
                valid_d = 1'b1;
                step_d  = '0;
                cnt_d   = shamt;
                if (dec_shift && shamt != '0) begin
                    ctrl_d  = dec_code;
                    bz_d    = 1'b0;
                    last_d  = (shamt == ONE);
                    busy_d  = (shamt != ONE);
                    state_d = (shamt == ONE) ? ISSUE : SHIFT;
                end else if (dec_shift) begin
                    // Zero shift: ADD with B forced to 0 passes A through.
                    ctrl_d  = C_ADD;
                    bz_d    = 1'b1;
                    last_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ISSUE;
                end else begin
                    ctrl_d  = dec_code;
                    bz_d    = 1'b0;
                    last_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ISSUE;
                end
            end else if (state_q == SHIFT && !last_q) begin
                step_d = step_q + ONE;
                last_d = (step_q + ONE == cnt_q - ONE);
                busy_d = (step_q + ONE != cnt_q - ONE);
            end else begin
                state_d = IDLE;
                ctrl_d  = C_ADD;
                bz_d    = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
                step_d  = '0;
            end
        end
`ifdef ALU_SEQ_FLUSH_EN
        // Flush wins over stall and over a same-cycle accept.
        if (flush) begin
            state_d = IDLE;
            ctrl_d  = C_ADD;
            bz_d    = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            step_d  = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctrl_q  <= C_ADD;
            bz_q    <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            bz_q    <= bz_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed scenarios plus a randomized run checked
// against a command-list reference model of the sequencer.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] alu_op = '0;
    logic [2:0] funct = '0;
    logic [2:0] shamt = '0;
    logic       stall = 1'b0;
`ifdef ALU_SEQ_FLUSH_EN
    logic       flush = 1'b0;
`endif
    logic [2:0] alu_ctrl;
    logic       alu_b_zero;
    logic       ctrl_valid;
    logic       ctrl_last;
    logic [2:0] step;
    logic       busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .funct      (funct),
        .shamt      (shamt),
        .stall      (stall),
`ifdef ALU_SEQ_FLUSH_EN
        .flush      (flush),
`endif
        .alu_ctrl   (alu_ctrl),
        .alu_b_zero (alu_b_zero),
        .ctrl_valid (ctrl_valid),
        .ctrl_last  (ctrl_last),
        .step       (step),
        .busy       (busy)
    );

    // {valid, last, busy, b_zero, code[2:0], step[2:0]}
    logic [9:0] obs;
    assign obs = {ctrl_valid, ctrl_last, busy, alu_b_zero, alu_ctrl, step};

    function automatic logic [9:0] pk(input logic v, input logic l,
                                      input logic b, input logic z,
                                      input logic [2:0] c,
                                      input logic [2:0] s);
        return {v, l, b, z, c, s};
    endfunction

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [2:0] fn, input logic [2:0] sh,
                         input logic st);
        @(negedge clk);
        in_valid = v;
        alu_op   = op;
        funct    = fn;
        shamt    = sh;
        stall    = st;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if (obs !== 10'd0)
            $display("FAIL reset_outputs got %h want %h", obs, 10'd0);
        else passes++;
        checks++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_ready got %b want 1", in_ready);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [1:0] ops [3];
        logic [2:0] codes [3];
        ops   = '{2'b00, 2'b01, 2'b11};
        codes = '{3'd0, 3'd1, 3'd7};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], 3'b101, 3'd4, 1'b0);
            checks++;
            if (in_ready !== 1'b1)
                $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready);
            else passes++;
            tick();
            checks++;
            if (obs !== pk(1, 1, 0, 0, codes[i], 0))
                $display("FAIL b2b_cmd[%0d] got %h want %h", i, obs,
                         pk(1, 1, 0, 0, codes[i], 0));
            else passes++;
        end
        drive(1'b0, 2'b00, 3'b000, 3'd0, 1'b0);
        tick();
        checks++;
        if (ctrl_valid !== 1'b0)
            $display("FAIL b2b_idle got %b want 0", ctrl_valid);
        else passes++;
    endtask

    task automatic test_shift_burst;
        drive(1'b1, 2'b10, 3'b110, 3'd7, 1'b0);
        tick();
        for (int i = 0; i < 7; i++) begin
            // Next request held on the inputs throughout the burst.
            drive(1'b1, 2'b01, 3'b000, 3'd0, 1'b0);
            checks++;
            if (obs !== pk(1, i == 6, i != 6, 0, 3'd6, 3'(i)))
                $display("FAIL shr_step[%0d] got %h want %h", i, obs,
                         pk(1, i == 6, i != 6, 0, 3'd6, 3'(i)));
            else passes++;
            checks++;
            if (in_ready !== (i == 6))
                $display("FAIL shr_ready[%0d] got %b want %b", i,
                         in_ready, i == 6);
            else passes++;
            tick();
        end
        checks++;
        if (obs !== pk(1, 1, 0, 0, 3'd1, 0))
            $display("FAIL shr_next got %h want %h", obs,
                     pk(1, 1, 0, 0, 3'd1, 0));
        else passes++;
        drive(1'b0, 2'b00, 3'b000, 3'd0, 1'b0);
        tick();
    endtask

    task automatic test_shift_zero;
        drive(1'b1, 2'b10, 3'b101, 3'd0, 1'b0);
        tick();
        checks++;
        if (obs !== pk(1, 1, 0, 1, 3'd0, 0))
            $display("FAIL shz_cmd got %h want %h", obs,
                     pk(1, 1, 0, 1, 3'd0, 0));
        else passes++;
        drive(1'b0, 2'b00, 3'b000, 3'd0, 1'b0);
        tick();
        checks++;
        if ({ctrl_valid, busy, alu_b_zero} !== 3'b000)
            $display("FAIL shz_idle got %b want 000",
                     {ctrl_valid, busy, alu_b_zero});
        else passes++;
    endtask

    task automatic test_stall;
        logic [9:0] seq [6];
        logic       st [6];
        seq = '{pk(1, 0, 1, 0, 5, 0), pk(1, 0, 1, 0, 5, 1),
                pk(1, 0, 1, 0, 5, 1), pk(1, 0, 1, 0, 5, 1),
                pk(1, 1, 0, 0, 5, 2), pk(0, 0, 0, 0, 0, 0)};
        st  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        drive(1'b1, 2'b10, 3'b101, 3'd3, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs !== seq[i])
                $display("FAIL stall_cyc[%0d] got %h want %h", i, obs,
                         seq[i]);
            else passes++;
            drive(1'b0, 2'b00, 3'b000, 3'd0, st[i]);
            if (i == 1 || i == 2) begin
                checks++;
                if (in_ready !== 1'b0)
                    $display("FAIL stall_ready[%0d] got %b want 0", i,
                             in_ready);
                else passes++;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_burst;
        drive(1'b1, 2'b10, 3'b101, 3'd5, 1'b0);
        tick();
        drive(1'b0, 2'b00, 3'b000, 3'd0, 1'b0);
        tick();
        checks++;
        if (obs !== pk(1, 0, 1, 0, 5, 1))
            $display("FAIL rmb_second got %h want %h", obs,
                     pk(1, 0, 1, 0, 5, 1));
        else passes++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 10'd0)
            $display("FAIL rmb_async got %h want 0", obs);
        else passes++;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({ctrl_valid, busy, in_ready} !== 3'b001)
            $display("FAIL rmb_idle got %b want 001",
                     {ctrl_valid, busy, in_ready});
        else passes++;
    endtask

`ifdef ALU_SEQ_FLUSH_EN
    task automatic test_flush;
        drive(1'b1, 2'b10, 3'b101, 3'd6, 1'b0);
        tick();
        drive(1'b0, 2'b00, 3'b000, 3'd0, 1'b0);
        tick();
        tick();
        checks++;
        if (obs !== pk(1, 0, 1, 0, 5, 2))
            $display("FAIL flush_step2 got %h want %h", obs,
                     pk(1, 0, 1, 0, 5, 2));
        else passes++;
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        alu_op = 2'b11;
        tick();
        checks++;
        if ({ctrl_valid, busy, step} !== 5'b0)
            $display("FAIL flush_drop got %b want 0",
                     {ctrl_valid, busy, step});
        else passes++;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++;
        if (ctrl_valid !== 1'b0)
            $display("FAIL flush_noconsume got %b want 0", ctrl_valid);
        else passes++;
    endtask
`endif

    // Reference model: each accepted request expands into its full list
    // of commands; the outputs simply walk that list one per free cycle.
    logic [9:0] q [$];
    logic [9:0] cur;

    task automatic expand(input logic [1:0] op, input logic [2:0] fn,
                          input logic [2:0] sh);
        int code;
        bit is_sh;
        is_sh = 0;
        case (op)
            2'd0: code = 0;
            2'd1: code = 1;
            2'd3: code = 7;
            default: begin
                if (fn == 3'd5 || fn == 3'd6) begin
                    is_sh = 1;
                    code = fn;
                end else begin
                    code = fn;
                end
            end
        endcase
        q.delete();
        if (is_sh && sh == 0)
            q.push_back(pk(1, 1, 0, 1, 0, 0));
        else if (is_sh)
            for (int k = 0; k < sh; k++)
                q.push_back(pk(1, k == sh - 1, k != sh - 1, 0,
                               3'(code), 3'(k)));
        else
            q.push_back(pk(1, 1, 0, 0, 3'(code), 0));
    endtask

    task automatic test_random;
        logic       v, st, exp_rdy;
        logic [1:0] op;
        logic [2:0] fn, sh;
        drive(1'b0, 2'b00, 3'b000, 3'd0, 1'b0);
        tick();
        cur = '0;
        q.delete();
        for (int i = 0; i < 400; i++) begin
            v  = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            fn = 3'($urandom_range(0, 7));
            sh = 3'($urandom_range(0, 7));
            st = ($urandom_range(0, 4) == 0);
            drive(v, op, fn, sh, st);
            exp_rdy = !st && (!cur[9] || cur[8]);
            checks++;
            if (in_ready !== exp_rdy)
                $display("FAIL rnd_ready[%0d] got %b want %b", i,
                         in_ready, exp_rdy);
            else passes++;
            @(posedge clk);
            if (!st) begin
                if (v && exp_rdy) begin
                    expand(op, fn, sh);
                    cur = q.pop_front();
                end else if (q.size() > 0) begin
                    cur = q.pop_front();
                end else begin
                    cur = '0;
                end
            end
            #1;
            checks++;
            if (cur[9] ? (obs !== cur) : (obs[9:7] !== 3'b000))
                $display("FAIL rnd_cmd[%0d] got %h want %h", i, obs, cur);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_shift_burst();
        test_shift_zero();
        test_stall();
        test_reset_mid_burst();
`ifdef ALU_SEQ_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
